// File: rtl/lsu_dmem_responder.sv
// ----------------------------------------------------------------------------
// lsu_dmem_responder
//
// Memory-side responder for the LSU execute-stage request interface. Holds a
// word-addressed data RAM, serves one load and one store per cycle with a
// single-cycle load latency, and flags misaligned or out-of-range accesses.
// After reset an init sweep zero-fills the RAM. While the sweep runs, busy is
// high and every request is dropped and reported as an error.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two, >= 2)
//   BASE_ADDR  byte address of word 0 (DEPTH*4 aligned)
//
// Ports
//   clk       clock, all state on the rising edge
//   rst       synchronous reset, active high
//   rd_en     load request this cycle
//   rd_addr   load byte address
//   wr_en     store request this cycle
//   wr_addr   store byte address
//   wr_data   store data
//   rd_data   load data, qualified by rd_valid; holds its value when idle
//   rd_valid  result of the load issued last cycle is present
//   rd_err    load issued last cycle was bad or was dropped while busy
//   wr_err    store issued last cycle was bad or was dropped while busy
//   busy      init sweep in progress
// ----------------------------------------------------------------------------
module lsu_dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_err,
    output logic        wr_err,
    output logic        busy
);

    localparam int          AW   = $clog2(DEPTH);
    // Size of the window in bytes, kept at 33 bits so that a window ending
    // exactly at 2^32 is still representable.
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            init_we;

    logic [31:0]     mem [DEPTH];

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        init_we = 1'b0;
        case (state_q)
            INIT: begin
                busy    = 1'b1;
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode
    // The offset is taken in 33 bits: an address below BASE_ADDR borrows
    // into bit 32, so a single unsigned compare against SPAN catches both
    // the underflow and the overflow side with no wrap-around.
    // ------------------------------------------------------------------
    logic [32:0]   rd_off, wr_off;
    logic [AW-1:0] rd_idx, wr_idx;
    logic          rd_bad, wr_bad;
    logic          rd_ok, wr_ok;
    logic          fwd;

    assign rd_off = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    assign wr_off = {1'b0, wr_addr} - {1'b0, BASE_ADDR};

    assign rd_idx = AW'(rd_off >> 2);
    assign wr_idx = AW'(wr_off >> 2);

    assign rd_bad = (rd_addr[1:0] != 2'b00) || (rd_off >= SPAN);
    assign wr_bad = (wr_addr[1:0] != 2'b00) || (wr_off >= SPAN);

    assign rd_ok  = !busy && !rd_bad;
    assign wr_ok  = !busy && !wr_bad;

    // Write-first: a legal store to the word being loaded this cycle is
    // returned directly instead of the stale RAM contents.
    assign fwd    = wr_en && wr_ok && (wr_idx == rd_idx);

    // ------------------------------------------------------------------
    // RAM write port, shared between the init sweep and stores
    // ------------------------------------------------------------------
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_idx;
        mem_wdata = wr_data;
        if (!rst) begin
            if (init_we) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
            end else if (wr_en && wr_ok) begin
                mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_ok;
            wr_err   <= wr_en && !wr_ok;
            if (rd_en) begin
                if (!rd_ok) begin
                    rd_data <= '0;
                end else if (fwd) begin
                    rd_data <= wr_data;
                end else begin
                    rd_data <= mem[rd_idx];
                end
            end
        end
    end

endmodule
